// File: rtl/simon_pkg.sv
// Shared colour/status codes and FSM state encoding for the simon player-side checker.
package simon_pkg;

  // Button / sequence colour codes
  localparam logic [1:0] RED = 2'd0;
  localparam logic [1:0] GRN = 2'd1;
  localparam logic [1:0] BLU = 2'd2;
  localparam logic [1:0] YEL = 2'd3;

  // Status codes reported back to the game core
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_PASS = 2'b10;
  localparam logic [1:0] ST_FAIL = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StPass,
    StFail
  } state_e;

  // LOAD and CHECK both look BUSY to the game core
  function automatic logic [1:0] state_to_status(input state_e s);
    logic [1:0] st;
    st = ST_IDLE;
    case (s)
      StIdle:          st = ST_IDLE;
      StLoad, StCheck: st = ST_BUSY;
      StPass:          st = ST_PASS;
      StFail:          st = ST_FAIL;
      default:         st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Colour sequence storage: Depth x 2-bit register file, one write port, one async read port.
module simon_seq_mem #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [1:0]    wr_data_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [1:0]    rd_data_o
);

  // Contents are deliberately not reset; only entries below seq_len are ever read.
  logic [1:0] mem_q [Depth];

  // Write the addressed entry
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < Depth; i++) begin
      if (we_i && (wr_idx_i == AW'(i))) begin
        mem_q[i] <= wr_data_i;
      end
    end
  end

  // Async read; out-of-range indices (progress == Depth after PASS) return 0
  always_comb begin
    rd_data_o = 2'd0;
    for (int i = 0; i < Depth; i++) begin
      if (rd_idx_i == AW'(i)) begin
        rd_data_o = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/simon_checker.sv
// Player-side simon checker: stores the game's colour sequence, then checks button presses
// against it with a per-press timeout, reporting IDLE/BUSY/PASS/FAIL.
module simon_checker import simon_pkg::*; #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         seq_valid,
  input  logic [1:0]                   seq_color,
  output logic                         seq_ready,
  input  logic                         seq_done,
  input  logic                         btn_valid,
  input  logic [1:0]                   btn_color,
  output logic [1:0]                   status,
  output logic [$clog2(MAX_LEN+1)-1:0] progress,
  output logic [$clog2(MAX_LEN+1)-1:0] seq_len
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [LW-1:0] MaxLen      = LW'(MAX_LEN);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYC - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] prog_q, prog_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    status_q, status_d;
  logic          ready_q, ready_d;

  logic          mem_we;
  logic [LW-1:0] mem_widx;
  logic [1:0]    mem_rdata;

  simon_seq_mem #(
    .Depth (MAX_LEN),
    .AW    (LW)
  ) u_seq_mem (
    .clk_i     (clock),
    .we_i      (mem_we),
    .wr_idx_i  (mem_widx),
    .wr_data_i (seq_color),
    .rd_idx_i  (prog_q),
    .rd_data_o (mem_rdata)
  );

  // Next-state, counters and memory write control; clear overrides everything
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    prog_d   = prog_q;
    timer_d  = timer_q;
    mem_we   = 1'b0;
    mem_widx = len_q;

    if (clear) begin
      state_d = StIdle;
      len_d   = '0;
      prog_d  = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (seq_valid) begin
            mem_we   = 1'b1;
            mem_widx = '0;
            len_d    = LW'(1);
            state_d  = StLoad;
          end
        end
        StLoad: begin
          // Elements offered while full are silently dropped
          if (seq_valid && (len_q < MaxLen)) begin
            mem_we = 1'b1;
            len_d  = len_q + LW'(1);
          end
          if (seq_done) begin
            state_d = StCheck;
            prog_d  = '0;
            timer_d = '0;
          end
        end
        StCheck: begin
          // A press in the timeout cycle takes precedence over the timeout
          if (btn_valid) begin
            if (btn_color != mem_rdata) begin
              state_d = StFail;
            end else if (prog_q == (len_q - LW'(1))) begin
              state_d = StPass;
              prog_d  = len_q;
            end else begin
              prog_d  = prog_q + LW'(1);
              timer_d = '0;
            end
          end else if (timer_q == TimeoutLast) begin
            state_d = StFail;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: ;
      endcase
    end

    status_d = state_to_status(state_d);
    ready_d  = (state_d == StIdle) || ((state_d == StLoad) && (len_d < MaxLen));
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      len_q    <= '0;
      prog_q   <= '0;
      timer_q  <= '0;
      status_q <= ST_IDLE;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      prog_q   <= prog_d;
      timer_q  <= timer_d;
      status_q <= status_d;
      ready_q  <= ready_d;
    end
  end

  assign seq_ready = ready_q;
  assign status    = status_q;
  assign progress  = prog_q;
  assign seq_len   = len_q;

endmodule

// File: tb/tb_simon_checker.sv
// Scoreboard bench for simon_checker (MAX_LEN=4, TIMEOUT_CYC=8). Stimulus pushes the expected
// output tuple and the cycle it must appear in; the monitor pops on every output change.
module tb_simon_checker;
  import simon_pkg::*;

  localparam int unsigned MAX_LEN     = 4;
  localparam int unsigned TIMEOUT_CYC = 8;
  localparam int unsigned LW          = $clog2(MAX_LEN + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          clear;
  logic          seq_valid;
  logic [1:0]    seq_color;
  logic          seq_ready;
  logic          seq_done;
  logic          btn_valid;
  logic [1:0]    btn_color;
  logic [1:0]    status;
  logic [LW-1:0] progress;
  logic [LW-1:0] seq_len;

  simon_checker #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .seq_valid (seq_valid),
    .seq_color (seq_color),
    .seq_ready (seq_ready),
    .seq_done  (seq_done),
    .btn_valid (btn_valid),
    .btn_color (btn_color),
    .status    (status),
    .progress  (progress),
    .seq_len   (seq_len)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]    st;
    logic [LW-1:0] prog;
    logic [LW-1:0] len;
    logic          rdy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic exp_push(input int at, input logic [1:0] st, input int prog, input int len,
                          input logic rdy);
    exp_t e;
    e.cyc    = at;
    e.o.st   = st;
    e.o.prog = LW'(prog);
    e.o.len  = LW'(len);
    e.o.rdy  = rdy;
    sb_q.push_back(e);
  endtask

  // Monitor: every change of the observed tuple must match the next expected entry
  obs_t prev_o;
  bit   have_prev = 1'b0;
  always @(negedge clock) begin
    obs_t cur;
    exp_t e;
    cur = '{st: status, prog: progress, len: seq_len, rdy: seq_ready};
    if (!have_prev || (cur != prev_o)) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_change cyc=%0d got st=%b prog=%0d len=%0d rdy=%b, none expected",
                 cyc, cur.st, cur.prog, cur.len, cur.rdy);
      end else begin
        e = sb_q.pop_front();
        if ((e.o != cur) || (e.cyc != cyc)) begin
          n_errors++;
          $display("FAIL output_change got cyc=%0d st=%b prog=%0d len=%0d rdy=%b, expected cyc=%0d st=%b prog=%0d len=%0d rdy=%b",
                   cyc, cur.st, cur.prog, cur.len, cur.rdy,
                   e.cyc, e.o.st, e.o.prog, e.o.len, e.o.rdy);
        end
      end
    end
    prev_o    = cur;
    have_prev = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_el(input logic [1:0] c, input bit chg, input int len, input logic rdy);
    seq_valid = 1'b1;
    seq_color = c;
    if (chg) exp_push(cyc + 1, ST_BUSY, 0, len, rdy);
    tick(1);
    seq_valid = 1'b0;
  endtask

  task automatic do_done(input int len);
    seq_done = 1'b1;
    exp_push(cyc + 1, ST_BUSY, 0, len, 1'b0);
    tick(1);
    seq_done = 1'b0;
  endtask

  task automatic press(input logic [1:0] c, input bit chg, input logic [1:0] st, input int prog,
                       input int len);
    btn_valid = 1'b1;
    btn_color = c;
    if (chg) exp_push(cyc + 1, st, prog, len, 1'b0);
    tick(1);
    btn_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    exp_push(cyc + 1, ST_IDLE, 0, 0, 1'b1);
    tick(1);
    clear = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    clear     = 1'b0;
    seq_valid = 1'b0;
    seq_color = RED;
    seq_done  = 1'b0;
    btn_valid = 1'b0;
    btn_color = RED;

    // Reset held for two clock edges
    exp_push(cyc + 1, ST_IDLE, 0, 0, 1'b1);
    tick(2);
    reset = 1'b1;
    tick(1);

    // IDLE ignores presses and seq_done
    press(YEL, 1'b0, ST_IDLE, 0, 0);
    seq_done = 1'b1;
    tick(1);
    seq_done = 1'b0;
    tick(1);

    // Load R,G,B; presses every 5 cycles -> PASS, progress 3
    push_el(RED, 1'b1, 1, 1'b1);
    push_el(GRN, 1'b1, 2, 1'b1);
    push_el(BLU, 1'b1, 3, 1'b1);
    do_done(3);
    tick(4);
    press(RED, 1'b1, ST_BUSY, 1, 3);
    tick(4);
    press(GRN, 1'b1, ST_BUSY, 2, 3);
    tick(4);
    press(BLU, 1'b1, ST_PASS, 3, 3);
    tick(2);
    press(RED, 1'b0, ST_PASS, 3, 3);  // sticky PASS
    do_clear();
    tick(1);

    // Load R,G; press R then Y -> FAIL with progress 1
    push_el(RED, 1'b1, 1, 1'b1);
    push_el(GRN, 1'b1, 2, 1'b1);
    do_done(2);
    tick(2);
    press(RED, 1'b1, ST_BUSY, 1, 2);
    press(YEL, 1'b1, ST_FAIL, 1, 2);
    tick(2);
    press(GRN, 1'b0, ST_FAIL, 1, 2);  // sticky FAIL
    do_clear();

    // Six elements into a 4-deep store: last two dropped
    push_el(RED, 1'b1, 1, 1'b1);
    push_el(GRN, 1'b1, 2, 1'b1);
    push_el(BLU, 1'b1, 3, 1'b1);
    push_el(YEL, 1'b1, 4, 1'b0);
    push_el(RED, 1'b0, 4, 1'b0);
    push_el(RED, 1'b0, 4, 1'b0);
    seq_done = 1'b1;  // LOAD->CHECK leaves the tuple unchanged here
    tick(1);
    seq_done = 1'b0;
    press(RED, 1'b1, ST_BUSY, 1, 4);
    press(GRN, 1'b1, ST_BUSY, 2, 4);
    press(BLU, 1'b1, ST_BUSY, 3, 4);
    press(YEL, 1'b1, ST_PASS, 4, 4);
    do_clear();

    // seq_valid and seq_done together on the 4th element
    push_el(YEL, 1'b1, 1, 1'b1);
    push_el(BLU, 1'b1, 2, 1'b1);
    push_el(GRN, 1'b1, 3, 1'b1);
    seq_valid = 1'b1;
    seq_done  = 1'b1;
    seq_color = RED;
    exp_push(cyc + 1, ST_BUSY, 0, 4, 1'b0);
    tick(1);
    seq_valid = 1'b0;
    seq_done  = 1'b0;
    press(YEL, 1'b1, ST_BUSY, 1, 4);
    press(BLU, 1'b1, ST_BUSY, 2, 4);
    press(GRN, 1'b1, ST_BUSY, 3, 4);
    press(RED, 1'b1, ST_PASS, 4, 4);
    do_clear();

    // Timeout: FAIL exactly 8 cycles after entering CHECK
    push_el(GRN, 1'b1, 1, 1'b1);
    do_done(1);
    exp_push(cyc + 8, ST_FAIL, 0, 1, 1'b0);
    tick(8);
    do_clear();

    // Press in the 8th cycle beats the timeout
    push_el(GRN, 1'b1, 1, 1'b1);
    do_done(1);
    tick(7);
    press(GRN, 1'b1, ST_PASS, 1, 1);
    tick(1);
    do_clear();

    // Reset mid-CHECK aborts at once; later presses are ignored
    push_el(RED, 1'b1, 1, 1'b1);
    push_el(BLU, 1'b1, 2, 1'b1);
    do_done(2);
    tick(1);
    press(RED, 1'b1, ST_BUSY, 1, 2);
    tick(2);
    reset = 1'b0;
    exp_push(cyc, ST_IDLE, 0, 0, 1'b1);
    tick(2);
    reset = 1'b1;
    tick(1);
    press(BLU, 1'b0, ST_IDLE, 0, 0);
    press(RED, 1'b0, ST_IDLE, 0, 0);
    tick(4);

    // Every expected change must have been observed
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL pending_expectations got %0d left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
